// File: rtl/decode_writeback_if.sv
// ---------------------------------------------------------------------------
// decode_writeback_if
// Bundles every non-clock signal of the Y86-64 PIPE decode/write-back stage.
//   D_*        : D-register fields coming from fetch
//   E_bubble   : hazard-control request to load a bubble into E
//   e_/M_/m_/W_: forwarding sources; W_dst*/W_val* also drive the regfile writes
//   d_srcA/B   : combinational source ids handed back to hazard control
//   E_*        : registered E-stage fields
//   bubble_cnt : count of injected E bubbles (zero unless the counter is built)
// Modports: master = upstream/downstream pipeline, slave = the decode stage.
// ---------------------------------------------------------------------------
interface decode_writeback_if #(
  parameter int DATA_W = 64
);
  logic [2:0]        D_stat;
  logic [3:0]        D_icode;
  logic [3:0]        D_ifun;
  logic [3:0]        D_rA;
  logic [3:0]        D_rB;
  logic [DATA_W-1:0] D_valC;
  logic [DATA_W-1:0] D_valP;
  logic              E_bubble;
  logic [3:0]        e_dstE;
  logic [DATA_W-1:0] e_valE;
  logic [3:0]        M_dstE;
  logic [DATA_W-1:0] M_valE;
  logic [3:0]        M_dstM;
  logic [DATA_W-1:0] m_valM;
  logic [3:0]        W_dstE;
  logic [DATA_W-1:0] W_valE;
  logic [3:0]        W_dstM;
  logic [DATA_W-1:0] W_valM;
  logic [3:0]        d_srcA;
  logic [3:0]        d_srcB;
  logic [2:0]        E_stat;
  logic [3:0]        E_icode;
  logic [3:0]        E_ifun;
  logic [DATA_W-1:0] E_valC;
  logic [DATA_W-1:0] E_valA;
  logic [DATA_W-1:0] E_valB;
  logic [3:0]        E_dstE;
  logic [3:0]        E_dstM;
  logic [3:0]        E_srcA;
  logic [3:0]        E_srcB;
  logic [31:0]       bubble_cnt;

  modport master (
    output D_stat, D_icode, D_ifun, D_rA, D_rB, D_valC, D_valP, E_bubble,
           e_dstE, e_valE, M_dstE, M_valE, M_dstM, m_valM,
           W_dstE, W_valE, W_dstM, W_valM,
    input  d_srcA, d_srcB, E_stat, E_icode, E_ifun, E_valC, E_valA, E_valB,
           E_dstE, E_dstM, E_srcA, E_srcB, bubble_cnt
  );

  modport slave (
    input  D_stat, D_icode, D_ifun, D_rA, D_rB, D_valC, D_valP, E_bubble,
           e_dstE, e_valE, M_dstE, M_valE, M_dstM, m_valM,
           W_dstE, W_valE, W_dstM, W_valM,
    output d_srcA, d_srcB, E_stat, E_icode, E_ifun, E_valC, E_valA, E_valB,
           E_dstE, E_dstM, E_srcA, E_srcB, bubble_cnt
  );
endinterface

// File: rtl/decode_writeback_stage.sv
// ---------------------------------------------------------------------------
// decode_writeback_stage
// Y86-64 PIPE decode stage with the register file (written from W).
// Selects srcA/srcB/dstE/dstM from the D fields, forwards valA/valB from
// e/M/m/W (or valP for call/jxx), reads the 15x64 register file
// asynchronously and registers everything into E on every clock edge.
// Ports:
//   clock : clock
//   reset : synchronous, active-high; clears regfile and loads a bubble into E
//   dw    : decode_writeback_if.slave carrying D, forwarding, W and E signals
// Build option: define DECODE_BUBBLECNT_EN to build the 32-bit E-bubble
// counter on dw.bubble_cnt; otherwise that output is constant zero.
// ---------------------------------------------------------------------------
module decode_writeback_stage #(
  parameter int DATA_W = 64,
  parameter int NREGS  = 15
) (
  input logic              clock,
  input logic              reset,
  decode_writeback_if.slave dw
);

  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;
  localparam logic [2:0] SBUB     = 3'd0;
  localparam logic [3:0] RRSP     = 4'h4;
  localparam logic [3:0] RNONE    = 4'hF;

  typedef struct packed {
    logic [2:0]        stat;
    logic [3:0]        icode;
    logic [3:0]        ifun;
    logic [DATA_W-1:0] val_c;
    logic [DATA_W-1:0] val_a;
    logic [DATA_W-1:0] val_b;
    logic [3:0]        dst_e;
    logic [3:0]        dst_m;
    logic [3:0]        src_a;
    logic [3:0]        src_b;
  } e_reg_t;

  localparam e_reg_t E_BUBBLE = '{
    stat: SBUB, icode: I_NOP, ifun: 4'h0,
    val_c: {DATA_W{1'b0}}, val_a: {DATA_W{1'b0}}, val_b: {DATA_W{1'b0}},
    dst_e: RNONE, dst_m: RNONE, src_a: RNONE, src_b: RNONE
  };

  logic [DATA_W-1:0] regs_q [NREGS];
  logic [3:0]        src_a_s, src_b_s, dst_e_s, dst_m_s;
  logic [DATA_W-1:0] rf_a_s, rf_b_s, val_a_s, val_b_s;
  e_reg_t            e_load_s, e_d, e_q;

  // Forwarding chain in priority order; an RNONE source never matches.
  function automatic logic [DATA_W-1:0] fwd_sel(
    input logic [3:0]        src,
    input logic [DATA_W-1:0] rf_val,
    input logic [3:0]        ex_dst_e, input logic [DATA_W-1:0] ex_val_e,
    input logic [3:0]        mem_dst_m, input logic [DATA_W-1:0] mem_val_m,
    input logic [3:0]        mem_dst_e, input logic [DATA_W-1:0] mem_val_e,
    input logic [3:0]        wb_dst_m, input logic [DATA_W-1:0] wb_val_m,
    input logic [3:0]        wb_dst_e, input logic [DATA_W-1:0] wb_val_e
  );
    logic [DATA_W-1:0] res;
    res = rf_val;
    if (src == RNONE)          res = rf_val;
    else if (src == ex_dst_e)  res = ex_val_e;
    else if (src == mem_dst_m) res = mem_val_m;
    else if (src == mem_dst_e) res = mem_val_e;
    else if (src == wb_dst_m)  res = wb_val_m;
    else if (src == wb_dst_e)  res = wb_val_e;
    else                       res = rf_val;
    return res;
  endfunction

  // Source/destination register selection from the D icode.
  always_comb begin
    src_a_s = RNONE;
    src_b_s = RNONE;
    dst_e_s = RNONE;
    dst_m_s = RNONE;
    case (dw.D_icode)
      I_RRMOVQ, I_RMMOVQ, I_OPQ, I_PUSHQ: src_a_s = dw.D_rA;
      I_POPQ, I_RET:                      src_a_s = RRSP;
      default:                            src_a_s = RNONE;
    endcase
    case (dw.D_icode)
      I_OPQ, I_RMMOVQ, I_MRMOVQ:          src_b_s = dw.D_rB;
      I_PUSHQ, I_POPQ, I_CALL, I_RET:     src_b_s = RRSP;
      default:                            src_b_s = RNONE;
    endcase
    case (dw.D_icode)
      I_RRMOVQ, I_IRMOVQ, I_OPQ:          dst_e_s = dw.D_rB;
      I_PUSHQ, I_POPQ, I_CALL, I_RET:     dst_e_s = RRSP;
      default:                            dst_e_s = RNONE;
    endcase
    case (dw.D_icode)
      I_MRMOVQ, I_POPQ:                   dst_m_s = dw.D_rA;
      default:                            dst_m_s = RNONE;
    endcase
  end

  // Asynchronous regfile read; RNONE reads as zero.
  assign rf_a_s = (src_a_s == RNONE) ? {DATA_W{1'b0}} : regs_q[src_a_s];
  assign rf_b_s = (src_b_s == RNONE) ? {DATA_W{1'b0}} : regs_q[src_b_s];

  // valA/valB selection; call/jxx carry valP down the valA path.
  always_comb begin
    val_a_s = fwd_sel(src_a_s, rf_a_s, dw.e_dstE, dw.e_valE, dw.M_dstM, dw.m_valM,
                      dw.M_dstE, dw.M_valE, dw.W_dstM, dw.W_valM, dw.W_dstE, dw.W_valE);
    val_b_s = fwd_sel(src_b_s, rf_b_s, dw.e_dstE, dw.e_valE, dw.M_dstM, dw.m_valM,
                      dw.M_dstE, dw.M_valE, dw.W_dstM, dw.W_valM, dw.W_dstE, dw.W_valE);
    if ((dw.D_icode == I_CALL) || (dw.D_icode == I_JXX)) begin
      val_a_s = dw.D_valP;
    end else begin
      val_a_s = val_a_s;
    end
  end

  // E next-state: decoded fields, or a bubble when hazard control asks.
  always_comb begin
    e_load_s = '{
      stat: dw.D_stat, icode: dw.D_icode, ifun: dw.D_ifun,
      val_c: dw.D_valC, val_a: val_a_s, val_b: val_b_s,
      dst_e: dst_e_s, dst_m: dst_m_s, src_a: src_a_s, src_b: src_b_s
    };
    e_d = e_load_s;
    if (dw.E_bubble) begin
      e_d = E_BUBBLE;
    end else begin
      e_d = e_load_s;
    end
  end

  // E pipeline register; never stalls, reset discards in-flight contents.
  always_ff @(posedge clock) begin
    if (reset) begin
      e_q <= E_BUBBLE;
    end else begin
      e_q <= e_d;
    end
  end

  // Regfile write ports: M is written after E so popq %rsp keeps valM.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= {DATA_W{1'b0}};
      end
    end else begin
      if (dw.W_dstE != RNONE) begin
        regs_q[dw.W_dstE] <= dw.W_valE;
      end
      if (dw.W_dstM != RNONE) begin
        regs_q[dw.W_dstM] <= dw.W_valM;
      end
    end
  end

  assign dw.d_srcA  = src_a_s;
  assign dw.d_srcB  = src_b_s;
  assign dw.E_stat  = e_q.stat;
  assign dw.E_icode = e_q.icode;
  assign dw.E_ifun  = e_q.ifun;
  assign dw.E_valC  = e_q.val_c;
  assign dw.E_valA  = e_q.val_a;
  assign dw.E_valB  = e_q.val_b;
  assign dw.E_dstE  = e_q.dst_e;
  assign dw.E_dstM  = e_q.dst_m;
  assign dw.E_srcA  = e_q.src_a;
  assign dw.E_srcB  = e_q.src_b;

`ifdef DECODE_BUBBLECNT_EN
  logic [31:0] bubble_cnt_q;

  // Counts bubbles injected outside reset; wraps naturally.
  always_ff @(posedge clock) begin
    if (reset) begin
      bubble_cnt_q <= 32'd0;
    end else if (dw.E_bubble) begin
      bubble_cnt_q <= bubble_cnt_q + 32'd1;
    end
  end

  assign dw.bubble_cnt = bubble_cnt_q;
`else
  assign dw.bubble_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_decode_writeback_stage.sv
module tb_decode_writeback_stage;
  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  decode_writeback_if #(.DATA_W(64)) dw ();

  decode_writeback_stage #(.DATA_W(64), .NREGS(15)) dut (
    .clock (clock),
    .reset (reset),
    .dw    (dw.slave)
  );

`ifdef DECODE_BUBBLECNT_EN
  localparam logic [31:0] EXP_BCNT = 32'd1;
`else
  localparam logic [31:0] EXP_BCNT = 32'd0;
`endif

  typedef struct {
    int          tag;
    int          due;
    logic [2:0]  stat;
    logic [3:0]  icode;
    logic [3:0]  ifun;
    logic [63:0] valc;
    logic [63:0] vala;
    logic [63:0] valb;
    logic [3:0]  dste;
    logic [3:0]  dstm;
    logic [3:0]  srca;
    logic [3:0]  srcb;
  } exp_t;

  exp_t sb_q[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always @(posedge clock) cyc <= cyc + 1;

  function automatic void chk(string name, int tag, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %h expected %h", name, tag, act, exp);
    end
  endfunction

  // Monitor: E is a new output every edge; compare matured expectations.
  always @(negedge clock) begin
    exp_t e;
    while (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
      e = sb_q.pop_front();
      chk("E_stat",  e.tag, 64'(dw.E_stat),  64'(e.stat));
      chk("E_icode", e.tag, 64'(dw.E_icode), 64'(e.icode));
      chk("E_ifun",  e.tag, 64'(dw.E_ifun),  64'(e.ifun));
      chk("E_valC",  e.tag, dw.E_valC, e.valc);
      chk("E_valA",  e.tag, dw.E_valA, e.vala);
      chk("E_valB",  e.tag, dw.E_valB, e.valb);
      chk("E_dstE",  e.tag, 64'(dw.E_dstE), 64'(e.dste));
      chk("E_dstM",  e.tag, 64'(dw.E_dstM), 64'(e.dstm));
      chk("E_srcA",  e.tag, 64'(dw.E_srcA), 64'(e.srca));
      chk("E_srcB",  e.tag, 64'(dw.E_srcB), 64'(e.srcb));
    end
  end

  task automatic fw(input logic [3:0] ed, input logic [63:0] ev,
                    input logic [3:0] med, input logic [63:0] mev,
                    input logic [3:0] mmd, input logic [63:0] mmv,
                    input logic [3:0] wed, input logic [63:0] wev,
                    input logic [3:0] wmd, input logic [63:0] wmv);
    dw.e_dstE = ed;  dw.e_valE = ev;
    dw.M_dstE = med; dw.M_valE = mev;
    dw.M_dstM = mmd; dw.m_valM = mmv;
    dw.W_dstE = wed; dw.W_valE = wev;
    dw.W_dstM = wmd; dw.W_valM = wmv;
  endtask

  task automatic fw_none();
    fw(4'hF, 64'h0, 4'hF, 64'h0, 4'hF, 64'h0, 4'hF, 64'h0, 4'hF, 64'h0);
  endtask

  task automatic drv(input logic rst, input logic bub, input logic [2:0] stat,
                     input logic [3:0] icode, input logic [3:0] ifun,
                     input logic [3:0] ra, input logic [3:0] rb,
                     input logic [63:0] valc, input logic [63:0] valp);
    reset = rst; dw.E_bubble = bub;
    dw.D_stat = stat; dw.D_icode = icode; dw.D_ifun = ifun;
    dw.D_rA = ra; dw.D_rB = rb; dw.D_valC = valc; dw.D_valP = valp;
  endtask

  task automatic expect_e(input int tag, input logic [2:0] stat, input logic [3:0] icode,
                          input logic [3:0] ifun, input logic [63:0] valc,
                          input logic [63:0] vala, input logic [63:0] valb,
                          input logic [3:0] dste, input logic [3:0] dstm,
                          input logic [3:0] srca, input logic [3:0] srcb);
    exp_t e;
    e.tag = tag; e.due = cyc + 1;
    e.stat = stat; e.icode = icode; e.ifun = ifun;
    e.valc = valc; e.vala = vala; e.valb = valb;
    e.dste = dste; e.dstm = dstm; e.srca = srca; e.srcb = srcb;
    sb_q.push_back(e);
  endtask

  task automatic expect_bubble(input int tag);
    expect_e(tag, 3'd0, 4'h1, 4'h0, 64'h0, 64'h0, 64'h0, 4'hF, 4'hF, 4'hF, 4'hF);
  endtask

  task automatic src_chk(input int tag, input logic [3:0] a, input logic [3:0] b);
    #1;
    chk("d_srcA", tag, 64'(dw.d_srcA), 64'(a));
    chk("d_srcB", tag, 64'(dw.d_srcB), 64'(b));
  endtask

  initial begin
    drv(1'b1, 1'b0, 3'd1, 4'h1, 4'h0, 4'hF, 4'hF, 64'h0, 64'h0);
    fw_none();

    // Reset cycles; the second also carries a W write and a bubble request.
    @(negedge clock);
    drv(1'b1, 1'b0, 3'd1, 4'h3, 4'h0, 4'hF, 4'h2, 64'h5, 64'hA);
    expect_bubble(100);
    @(negedge clock);
    fw(4'hF, 64'h0, 4'hF, 64'h0, 4'hF, 64'h0, 4'h1, 64'h55, 4'hF, 64'h0);
    drv(1'b1, 1'b1, 3'd1, 4'h3, 4'h0, 4'hF, 4'h2, 64'h5, 64'hA);
    expect_bubble(101);

    // 1: irmovq $5, %rdx
    @(negedge clock); fw_none();
    drv(1'b0, 1'b0, 3'd1, 4'h3, 4'h0, 4'hF, 4'h2, 64'h5, 64'hA);
    expect_e(1, 3'd1, 4'h3, 4'h0, 64'h5, 64'h0, 64'h0, 4'h2, 4'hF, 4'hF, 4'hF);
    src_chk(1, 4'hF, 4'hF);
    // 2: nop while W writes regfile[3]=7
    @(negedge clock);
    fw(4'hF, 64'h0, 4'hF, 64'h0, 4'hF, 64'h0, 4'h3, 64'h7, 4'hF, 64'h0);
    drv(1'b0, 1'b0, 3'd1, 4'h1, 4'h0, 4'hF, 4'hF, 64'h0, 64'h0);
    expect_e(2, 3'd1, 4'h1, 4'h0, 64'h0, 64'h0, 64'h0, 4'hF, 4'hF, 4'hF, 4'hF);
    // 3: opq with e and M_dstE both matching: e wins
    @(negedge clock);
    fw(4'h3, 64'h9, 4'h3, 64'h8, 4'hF, 64'h0, 4'hF, 64'h0, 4'hF, 64'h0);
    drv(1'b0, 1'b0, 3'd1, 4'h6, 4'h0, 4'h3, 4'h3, 64'h0, 64'h2);
    expect_e(3, 3'd1, 4'h6, 4'h0, 64'h0, 64'h9, 64'h9, 4'h3, 4'hF, 4'h3, 4'h3);
    src_chk(3, 4'h3, 4'h3);
    // 4: M_dstM beats M_dstE
    @(negedge clock);
    fw(4'hF, 64'h0, 4'h3, 64'h8, 4'h3, 64'h44, 4'hF, 64'h0, 4'hF, 64'h0);
    drv(1'b0, 1'b0, 3'd1, 4'h6, 4'h1, 4'h3, 4'h3, 64'h0, 64'h2);
    expect_e(4, 3'd1, 4'h6, 4'h1, 64'h0, 64'h44, 64'h44, 4'h3, 4'hF, 4'h3, 4'h3);
    // 5: W_dstM beats W_dstE; same-id write leaves regfile[3]=0x66
    @(negedge clock);
    fw(4'hF, 64'h0, 4'hF, 64'h0, 4'hF, 64'h0, 4'h3, 64'h77, 4'h3, 64'h66);
    drv(1'b0, 1'b0, 3'd1, 4'h2, 4'h0, 4'h3, 4'h5, 64'h0, 64'h2);
    expect_e(5, 3'd1, 4'h2, 4'h0, 64'h0, 64'h66, 64'h0, 4'h5, 4'hF, 4'h3, 4'hF);
    src_chk(5, 4'h3, 4'hF);
    // 6: both W ports target rsp: M port wins -> regfile[4]=2
    @(negedge clock);
    fw(4'hF, 64'h0, 4'hF, 64'h0, 4'hF, 64'h0, 4'h4, 64'h1, 4'h4, 64'h2);
    drv(1'b0, 1'b0, 3'd1, 4'h1, 4'h0, 4'hF, 4'hF, 64'h0, 64'h0);
    expect_e(6, 3'd1, 4'h1, 4'h0, 64'h0, 64'h0, 64'h0, 4'hF, 4'hF, 4'hF, 4'hF);
    // 7: plain regfile read of %rbx
    @(negedge clock); fw_none();
    drv(1'b0, 1'b0, 3'd1, 4'h2, 4'h0, 4'h3, 4'h6, 64'h0, 64'h2);
    expect_e(7, 3'd1, 4'h2, 4'h0, 64'h0, 64'h66, 64'h0, 4'h6, 4'hF, 4'h3, 4'hF);
    // 8: call: valA=valP, valB=regfile[rsp]
    @(negedge clock); fw_none();
    drv(1'b0, 1'b0, 3'd1, 4'h8, 4'h0, 4'hF, 4'hF, 64'h200, 64'h100);
    expect_e(8, 3'd1, 4'h8, 4'h0, 64'h200, 64'h100, 64'h2, 4'h4, 4'hF, 4'hF, 4'h4);
    src_chk(8, 4'hF, 4'h4);
    // 9: pushq %rsp with e forwarding on both operands
    @(negedge clock);
    fw(4'h4, 64'hAA, 4'hF, 64'h0, 4'hF, 64'h0, 4'hF, 64'h0, 4'hF, 64'h0);
    drv(1'b0, 1'b0, 3'd1, 4'hA, 4'h0, 4'h4, 4'hF, 64'h0, 64'h2);
    expect_e(9, 3'd1, 4'hA, 4'h0, 64'h0, 64'hAA, 64'hAA, 4'h4, 4'hF, 4'h4, 4'h4);
    src_chk(9, 4'h4, 4'h4);
    // 10: jxx carries valP in valA
    @(negedge clock);
    drv(1'b0, 1'b0, 3'd1, 4'h7, 4'h1, 4'hF, 4'hF, 64'h500, 64'h33);
    expect_e(10, 3'd1, 4'h7, 4'h1, 64'h500, 64'h33, 64'h0, 4'hF, 4'hF, 4'hF, 4'hF);
    // 11: bubble over a valid popq
    @(negedge clock); fw_none();
    drv(1'b0, 1'b1, 3'd1, 4'hB, 4'h0, 4'h1, 4'hF, 64'h0, 64'h2);
    expect_bubble(11);
    src_chk(11, 4'h4, 4'h4);
    // 12: popq %rcx
    @(negedge clock);
    drv(1'b0, 1'b0, 3'd1, 4'hB, 4'h0, 4'h1, 4'hF, 64'h0, 64'h2);
    expect_e(12, 3'd1, 4'hB, 4'h0, 64'h0, 64'h2, 64'h2, 4'h4, 4'h1, 4'h4, 4'h4);
    // 13: mrmovq 0x10(%rbx), %rcx
    @(negedge clock);
    drv(1'b0, 1'b0, 3'd1, 4'h5, 4'h0, 4'h1, 4'h3, 64'h10, 64'hA);
    expect_e(13, 3'd1, 4'h5, 4'h0, 64'h10, 64'h0, 64'h66, 4'hF, 4'h1, 4'hF, 4'h3);
    src_chk(13, 4'hF, 4'h3);
    // 14: regfile[1] untouched by the write issued during reset
    @(negedge clock);
    drv(1'b0, 1'b0, 3'd1, 4'h2, 4'h0, 4'h1, 4'h2, 64'h0, 64'h2);
    expect_e(14, 3'd1, 4'h2, 4'h0, 64'h0, 64'h0, 64'h0, 4'h2, 4'hF, 4'h1, 4'hF);
    // 15: same-cycle W write and read is forwarded
    @(negedge clock);
    fw(4'hF, 64'h0, 4'hF, 64'h0, 4'hF, 64'h0, 4'h5, 64'h1234, 4'hF, 64'h0);
    drv(1'b0, 1'b0, 3'd1, 4'h2, 4'h0, 4'h5, 4'h7, 64'h0, 64'h2);
    expect_e(15, 3'd1, 4'h2, 4'h0, 64'h0, 64'h1234, 64'h0, 4'h7, 4'hF, 4'h5, 4'hF);
    // 16: the value then sits in the regfile
    @(negedge clock); fw_none();
    drv(1'b0, 1'b0, 3'd1, 4'h2, 4'h0, 4'h5, 4'h7, 64'h0, 64'h2);
    expect_e(16, 3'd1, 4'h2, 4'h0, 64'h0, 64'h1234, 64'h0, 4'h7, 4'hF, 4'h5, 4'hF);
    // 17: mid-run reset with bubble: reset result, no count
    @(negedge clock);
    drv(1'b1, 1'b1, 3'd1, 4'h3, 4'h0, 4'hF, 4'h2, 64'h5, 64'hA);
    expect_bubble(17);
    src_chk(17, 4'hF, 4'hF);
    // 18: regfile cleared by reset (regs 3 and 5 read back zero)
    @(negedge clock);
    drv(1'b0, 1'b0, 3'd1, 4'h4, 4'h0, 4'h5, 4'h3, 64'h8, 64'hA);
    expect_e(18, 3'd1, 4'h4, 4'h0, 64'h8, 64'h0, 64'h0, 4'hF, 4'hF, 4'h5, 4'h3);

    @(negedge clock);
    @(negedge clock);
    chk("sb_drained", 0, 64'(sb_q.size()), 64'h0);
    chk("bubble_cnt", 0, 64'(dw.bubble_cnt), 64'(EXP_BCNT));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
